// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Number of byte lanes in a word of the given width.
    function automatic int unsigned lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Raw RAM array: per-lane synchronous write, asynchronous read, low-word watch taps.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned WATCH_N = 6
) (
    input  logic                      clk,
    input  logic [DATA_W/8-1:0]       we_lane_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [ADDR_W-1:0]         raddr_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [WATCH_N*DATA_W-1:0] watch_o
);

    localparam int unsigned LANES   = lanes(DATA_W);
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              w_in_range;
    logic              r_in_range;

    assign w_in_range = ({1'b0, waddr_i} < DEPTH_X);
    assign r_in_range = ({1'b0, raddr_i} < DEPTH_X);

    // Byte-lane write; lanes with a clear enable keep their contents.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (we_lane_i[l] && w_in_range) begin
                mem_q[IDX_W'(waddr_i)][l*8 +: 8] <= wdata_i[l*8 +: 8];
            end
        end
    end

    // Asynchronous read, zero for addresses past the array.
    assign rdata_o = r_in_range ? mem_q[IDX_W'(raddr_i)] : '0;

    // Low words fanned out for debug observation.
    for (genvar k = 0; k < WATCH_N; k++) begin : g_watch
        assign watch_o[k*DATA_W +: DATA_W] = mem_q[k];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: clear sequencer, access decode, registered read port.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned WATCH_N = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cs,
    input  logic                      we,
    input  logic                      oe,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       be,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    output logic                      err,
    output logic                      busy,
    output logic [WATCH_N*DATA_W-1:0] watch_out
);

    localparam int unsigned LANES = lanes(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    // Parameter legality checks at elaboration.
    if ((DATA_W == 0) || (DATA_W % 8 != 0)) begin : g_chk_data_w
        $error("data_mem_ctrl: DATA_W must be a non-zero multiple of 8");
    end
    if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_chk_depth
        $error("data_mem_ctrl: DEPTH must be in 1..2**ADDR_W");
    end
    if ((WATCH_N < 1) || (WATCH_N > DEPTH)) begin : g_chk_watch
        $error("data_mem_ctrl: WATCH_N must be in 1..DEPTH");
    end

    state_e             state_q;
    logic [ADDR_W-1:0]  clr_ptr_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rvalid_q;
    logic               err_q;

    logic               rd_acc;
    logic               wr_acc;
    logic               in_range;
    logic [LANES-1:0]   bank_we;
    logic [ADDR_W-1:0]  bank_waddr;
    logic [DATA_W-1:0]  bank_wdata;
    logic [DATA_W-1:0]  bank_rdata;

    assign busy     = (state_q == ST_CLEAR);
    assign rd_acc   = cs & oe & ~busy;
    assign wr_acc   = cs & we & ~oe & ~busy;
    assign in_range = ({1'b0, addr} < DEPTH_X);

    // Bank write port: clear sequencer owns it while busy, CPU otherwise.
    always_comb begin
        bank_we    = '0;
        bank_waddr = addr;
        bank_wdata = wdata;
        if (rst) begin
            bank_we = '0;
        end else if (busy) begin
            bank_we    = '1;
            bank_waddr = clr_ptr_q;
            bank_wdata = '0;
        end else if (wr_acc && in_range) begin
            bank_we = be;
        end
    end

    dmem_bank #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .WATCH_N (WATCH_N)
    ) u_bank (
        .clk       (clk),
        .we_lane_i (bank_we),
        .waddr_i   (bank_waddr),
        .wdata_i   (bank_wdata),
        .raddr_i   (addr),
        .rdata_o   (bank_rdata),
        .watch_o   (watch_out)
    );

    // Clear FSM, pointer and registered read/err outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            err_q    <= (rd_acc | wr_acc) & ~in_range;
            if (rd_acc) begin
                rdata_q <= in_range ? bank_rdata : '0;
            end
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q <= ST_READY;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule
